ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with prefetch. It issues sequential AXI4-lite read requests for instruction words, with up to MAX_OUTSTANDING requests in flight. Returned words are buffered with their PC in a BUF_DEPTH FIFO and handed to decode over a valid/ready handshake. It supports PC redirect with flush and discard of in-flight responses, and flags bus errors. It sits between the PC/redirect logic and decode, replacing the single-request fetch stage.

---
 rtl/ifu_prefetch.sv | 146 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with AXI4-lite read prefetch and instruction FIFO
//
// Issues sequential instruction-word reads (at most MAX_OUTSTANDING unanswered at a time).
// Returned words are queued with their PC for decode. Redirects flush the queue and
// discard in-flight responses. A bus error halts fetching until the next redirect.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect_valid/pc          flush and restart fetch at redirect_pc (word aligned)
//   out_valid/ready            decode handshake for the FIFO head entry
//   out_inst/pc/err            head entry: instruction, its PC, bus error flag
//   m_ar*                      AXI read address channel (master side)
//   m_r*                       AXI read data channel (master side, rready tied high)
module ifu_prefetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h8000_0000),
  parameter int              BUF_DEPTH       = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output logic [XLEN-1:0] m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [XLEN-1:0] m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW = $clog2(MAX_OUTSTANDING + 2);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] MAXO = MAX_OUTSTANDING;
  localparam logic [31:0] BUFD = BUF_DEPTH;

  logic [XLEN-1:0] fetch_pc;     // address of the next request to issue
  logic [OW-1:0]   outstanding;
  logic [DW-1:0]   discard;
  logic            halted;

  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] inst_mem [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] err_mem;

  // PCs of accepted ARs, oldest first; popped on every R handshake, dropped or not
  logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
  logic [QW-1:0]   q_wr, q_rd;

  logic            ar_hs, r_hs, ar_hold, pop, push, push_err, issue, halted_next;
  logic [OW-1:0]   outstanding_next;
  logic [CW-1:0]   count_next;
  logic            unused_pc_bits;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign m_rready  = 1'b1;       // space is reserved at issue, so responses are always accepted
  assign ar_hs     = m_arvalid & m_arready;
  assign r_hs      = m_rvalid & m_rready;
  assign ar_hold   = m_arvalid & ~m_arready;

  assign out_valid = (count != '0) && !redirect_valid;
  assign out_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;
  assign out_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
  assign out_err   = (count != '0) ? err_mem[rd_ptr]  : 1'b0;

  always_comb begin
    pop              = out_valid & out_ready;
    push             = r_hs && (discard == '0) && !redirect_valid;
    push_err         = push && (m_rresp != 2'b00);
    outstanding_next = outstanding + OW'(ar_hs) - OW'(r_hs);
    count_next       = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    halted_next      = redirect_valid ? 1'b0 : (halted | push_err);
    // Reserve a FIFO slot for every request in flight plus the one being issued
    issue = !halted_next && !ar_hold && !redirect_valid
            && (32'(outstanding_next) < MAXO)
            && (32'(count_next) + 32'(outstanding_next) < BUFD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      m_araddr    <= RESET_PC;
      m_arvalid   <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
    end else begin
      outstanding <= outstanding_next;
      halted      <= halted_next;
      count       <= count_next;

      if (redirect_valid) begin
        // A pending AR still completes at its old address, so its response is discarded too
        discard  <= DW'(outstanding_next) + DW'(ar_hold);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
        if (r_hs && (discard != '0)) discard <= discard - DW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      end

      if (issue) begin
        m_arvalid <= 1'b1;
        m_araddr  <= fetch_pc;
      end else if (!ar_hold) begin
        m_arvalid <= 1'b0;
      end

      if (ar_hs) q_wr <= q_inc(q_wr);
      if (r_hs)  q_rd <= q_inc(q_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) pcq[q_wr] <= m_araddr;
    if (push) begin
      inst_mem[wr_ptr] <= m_rdata;
      pc_mem[wr_ptr]   <= pcq[q_rd];
      err_mem[wr_ptr]  <= (m_rresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch with an AXI-lite slave model and scoreboard
module tb_ifu_prefetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_inst, out_pc;
  logic [31:0] m_araddr, m_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_rresp;

  ifu_prefetch #(.XLEN(32), .RESET_PC(RST_PC), .BUF_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_err(out_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } sq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } exp_t;

  sq_t         sq[$];
  exp_t        exp_q[$];
  logic [31:0] ar_log[$];
  logic [31:0] exp_next, err_addr, blk_addr, first_pc;
  logic        blk_en, err_hit, seen_out_err, want_first;
  int          cyc, lat, ar_cnt, ar_after_err, first_r_cyc, first_ov_cyc;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_a5a5;
  endfunction

  task automatic slave_drive();
    m_arready = !(blk_en && m_araddr == blk_addr);
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      m_rvalid = 1'b1;
      m_rdata  = word_of(sq[0].addr);
      m_rresp  = (sq[0].addr == err_addr) ? 2'b10 : 2'b00;
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = 2'b00;
    end
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge, update models after it
  task automatic step();
    logic arf, rf, of, rd, oe;
    logic [31:0] ara, ra, op, oi, rpc;
    exp_t e;
    sq_t s;
    slave_drive();
    #1;
    arf = m_arvalid && m_arready; ara = m_araddr;
    rf  = m_rvalid && m_rready;   ra  = (sq.size() > 0) ? sq[0].addr : 32'h0;
    of  = out_valid && out_ready; op  = out_pc; oi = out_inst; oe = out_err;
    rd  = redirect_valid;         rpc = redirect_pc;
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (rf && first_r_cyc < 0) first_r_cyc = cyc;
    @(posedge clk);
    cyc++;
    if (of) begin
      check("sb_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", op, e.pc);
        check("sb_inst", oi, e.inst);
        check("sb_err", oe, e.err);
      end
      if (want_first) begin first_pc = op; want_first = 1'b0; end
      if (oe) seen_out_err = 1'b1;
    end
    if (arf) begin
      if (err_hit) ar_after_err++;
      ar_log.push_back(ara);
      ar_cnt++;
      s.addr = ara; s.due = cyc + lat - 1;
      sq.push_back(s);
    end
    if (rf) begin
      void'(sq.pop_front());
      if (ra == err_addr) err_hit = 1'b1;
      if (!rd && ra == exp_next) begin
        e.pc = ra; e.inst = word_of(ra); e.err = (ra == err_addr);
        exp_q.push_back(e);
        exp_next = exp_next + 32'd4;
      end
    end
    if (rd) begin
      exp_q.delete();
      exp_next = {rpc[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic clear_models();
    sq.delete(); exp_q.delete(); ar_log.delete();
    exp_next = RST_PC; err_hit = 1'b0; ar_after_err = 0; seen_out_err = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; ar_cnt = 0;
    first_r_cyc = -1; first_ov_cyc = -1; first_pc = '0; want_first = 1'b0;
    err_addr = 32'hffff_ffff; blk_addr = '0; blk_en = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1; m_arready = 1'b1;
    rst_n = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);

    check("rst_arvalid", m_arvalid, 0);
    check("rst_araddr", m_araddr, RST_PC);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_err", out_err, 0);
    check("rst_rready", m_rready, 1);

    // Sequential fetch, 1-cycle slave
    rst_n = 1'b1;
    step();
    check("first_arvalid", m_arvalid, 1);
    check("first_araddr", m_araddr, RST_PC);
    run(20);
    for (int i = 0; i < 4; i++)
      check("seq_araddr", (ar_log.size() > i) ? ar_log[i] : 32'h0, RST_PC + 32'(4 * i));
    check("out_valid_lat", first_ov_cyc - first_r_cyc, 1);

    // Decode stalled: prefetch must stop once the buffer is reserved full
    out_ready = 1'b0;
    redirect(32'h8000_0100);
    ar_cnt = 0;
    run(30);
    check("stall_ar_count", ar_cnt, 4);
    check("stall_arvalid", m_arvalid, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ar_cnt = 0;
    run(15);
    check("one_pop_one_ar", ar_cnt, 1);
    out_ready = 1'b1;
    run(15);

    // Slow slave, redirect with two requests in flight
    lat = 5;
    run(15);
    check("inflight_before_redirect", sq.size(), 2);
    want_first = 1'b1; first_pc = '0;
    redirect(32'h8000_1002);
    run(30);
    check("redirect_first_pc", first_pc, 32'h8000_1000);

    // Redirect while an AR is stalled by the slave
    lat = 1; blk_en = 1'b1; blk_addr = 32'h8000_0010;
    reset_pulse();
    for (int i = 0; i < 40 && !(m_arvalid && m_araddr == blk_addr); i++) step();
    check("blk_reached", m_arvalid && m_araddr == blk_addr, 1);
    redirect(32'h8000_1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_hold", {m_arvalid, m_araddr}, {1'b1, 32'h8000_0010});
    end
    ar_log.delete();
    blk_en = 1'b0;
    want_first = 1'b1; first_pc = '0;
    run(20);
    check("held_ar_addr", (ar_log.size() > 0) ? ar_log[0] : 32'h0, 32'h8000_0010);
    check("post_hold_ar", (ar_log.size() > 1) ? ar_log[1] : 32'h0, 32'h8000_1000);
    check("post_hold_first_pc", first_pc, 32'h8000_1000);

    // Bus error halts fetch until redirect
    err_addr = 32'h8000_0008;
    reset_pulse();
    run(20);
    check("err_delivered", seen_out_err, 1);
    check("ar_after_err", ar_after_err, 0);
    check("err_arvalid", m_arvalid, 0);
    ar_log.delete();
    want_first = 1'b1; first_pc = '0;
    redirect(32'h8000_2000);
    run(12);
    check("resume_ar", (ar_log.size() > 0) ? ar_log[0] : 32'h0, 32'h8000_2000);
    check("resume_first_pc", first_pc, 32'h8000_2000);

    // Asynchronous reset in the middle of a burst
    err_addr = 32'hffff_ffff;
    lat = 5;
    run(12);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_arvalid", m_arvalid, 0);
    check("arst_araddr", m_araddr, RST_PC);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pc", out_pc, 0);
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_fifo_empty", out_valid, 0);
    want_first = 1'b1; first_pc = '0;
    step();
    check("arst_restart", {m_arvalid, m_araddr}, {1'b1, RST_PC});
    run(25);
    check("arst_first_pc", first_pc, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
